pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, handshaked barrel shifter for the MIPS datapath, the successor of the fixed 32-bit combinational shifter. It supports logical-left, logical-right, arithmetic-right, rotate-left and rotate-right. It runs as a log2(WIDTH)-stage pipeline with valid/ready flow control and a pass-through tag. It sits between the ID/EX operand mux and the ALU result mux, and also serves the multi-cycle shift unit.

## Interface
- WIDTH, 32, data width; power of two, ≥ 4.
- SH_W, $clog2(WIDTH), shift-amount width; derived, do not override.
- TAG_W, 4, width of the opaque tag carried alongside data.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  operand.
- in_sh  input  SH_W  shift amount, 0..WIDTH-1.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 pass-through.
- in_tag  input  TAG_W  returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.
- out_zero  output  1  out_data == 0; qualified by out_valid.

## Operation
- Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
- advance = !out_valid || out_ready. in_ready = advance, combinational with no dependence on in_valid.
- On advance, every stage register loads from its predecessor. Stage 0 loads the input beat. The stage valid bit loads in_valid && in_ready.
- When advance = 0, the whole pipe holds. out_data, out_tag, out_zero and out_valid stay stable until accepted.
- Bubbles are not compacted. The global stall is intentional.
- Stage k (k = 0..SH_W-1) applies a shift of 2^k when in_sh[k] = 1. Op, remaining shift bits and tag are carried forward with the data.
- SLL and SRL fill vacated bits with 0. SRA fills with the operand's original bit WIDTH-1, carried from stage 0. ROL and ROR wrap the bits around.
- in_sh = 0 returns in_data unchanged for every op.
- Pass-through ops (101–111) return in_data unchanged and ignore in_sh.
- out_zero is registered alongside out_data, never derived from a stale value.
- Reset values: all stage valid bits 0, data 0, tag 0. Outputs: out_valid 0, out_data 0, out_tag 0, out_zero 0. in_ready is 1 one gate delay after reset, since out_valid = 0.
- Reset mid-operation: all in-flight beats are discarded. No beat reappears after reset deasserts.

## Timing
- Latency L = SH_W cycles (5 at WIDTH = 32) from an input transfer to out_valid, with BSHIFT_PIPE_EN defined and no stall.
- Latency L = 1 cycle without the macro.
- Throughput: one beat per cycle when out_ready is held at 1.
- A stall of N cycles delays every in-flight beat by exactly N cycles. Order is preserved.
- A simultaneous output accept and input accept in the same cycle is legal and loses no beat.
- rst_n assertion takes effect immediately. Deassertion is synchronised externally; the block assumes deassertion is clean relative to clk.

## Configuration
- BSHIFT_PIPE_EN defined: one register per shift stage. SH_W pipeline stages, L = SH_W.
- BSHIFT_PIPE_EN not defined: all stages combinational, followed by a single output register. L = 1.
- The handshake rules, reset values and results are identical in both builds; only the latency differs.

## Test plan
Use WIDTH = 32. Each latency below is L.

- SLL and SRL: in_data 0xFFFF0000. SLL by 5 → 0xFFE00000. SRL by 16 → 0x0000FFFF. Each appears L cycles after acceptance with the tag preserved.
- SRA and zero flag: 0x80000000 by 4 → 0xF8000000. 0x7FFFFFFF by 31 → 0x00000000 with out_zero = 1.
- Rotates and pass-through: 0xFFFF0000 ROL 4 → 0xFFF0000F. ROR 3 → 0x1FFFE000. Op 111 by 7 → 0xFFFF0000.
- Back-to-back stream: 8 beats with tags 0..7, out_ready = 1. Results arrive on 8 consecutive cycles in tag order, starting L cycles after the first.
- Backpressure: out_ready low for 3 cycles while the pipe is full. in_ready = 0 throughout and out_data is stable. Release yields all beats exactly once, in order.
- Reset mid-stream: assert rst_n = 0 with 3 beats in flight. out_valid drops to 0 immediately and out_data/out_tag read 0. After release, no stale beat emerges and a new beat completes with latency L.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Handshaked barrel shifter (SLL/SRL/SRA/ROL/ROR/pass) with a global-stall valid/ready pipe.
// Define BSHIFT_PIPE_EN for one register per shift stage (L = SH_W); otherwise L = 1.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH_W  = $clog2(WIDTH),
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_sh,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // One log-shifter stage: shift by 2^k when bit k of the amount is set.
  // SRA fills from the operand's original MSB, not the partially shifted value.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sign,
    input logic [SH_W-1:0]  sh,
    input int unsigned      k
  );
    logic [WIDTH-1:0] fill;
    logic             en;
    int unsigned      amt;
    amt  = 1 << k;
    en   = |(sh & ({{(SH_W-1){1'b0}}, 1'b1} << k));
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    shift_stage = d;
    if (en) begin
      case (op)
        OP_SLL:  shift_stage = d << amt;
        OP_SRL:  shift_stage = d >> amt;
        OP_SRA:  shift_stage = (d >> amt) | fill;
        OP_ROL:  shift_stage = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  shift_stage = (d >> amt) | (d << (WIDTH - amt));
        default: shift_stage = d;
      endcase
    end
  endfunction

`ifdef BSHIFT_PIPE_EN

  logic [SH_W-1:0]  v_q;
  logic [WIDTH-1:0] d_q    [SH_W];
  logic [TAG_W-1:0] tag_q  [SH_W];
  logic [2:0]       op_q   [SH_W-1];
  logic [SH_W-1:0]  sh_q   [SH_W-1];
  logic [SH_W-2:0]  sign_q;
  logic [WIDTH-1:0] nxt    [SH_W];
  logic             zero_q;

  always_comb begin
    nxt[0] = shift_stage(in_data, in_op, in_data[WIDTH-1], in_sh, 0);
    for (int unsigned k = 1; k < SH_W; k++) begin
      nxt[k] = shift_stage(d_q[k-1], op_q[k-1], sign_q[k-1], sh_q[k-1], k);
    end
  end

  // Control fields stop one stage early: the last stage only needs data and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      sign_q <= '0;
      zero_q <= 1'b0;
      for (int unsigned k = 0; k < SH_W; k++) begin
        d_q[k]   <= '0;
        tag_q[k] <= '0;
      end
      for (int unsigned k = 0; k < SH_W - 1; k++) begin
        op_q[k] <= '0;
        sh_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0]    <= in_valid && in_ready;
      d_q[0]    <= nxt[0];
      tag_q[0]  <= in_tag;
      op_q[0]   <= in_op;
      sh_q[0]   <= in_sh;
      sign_q[0] <= in_data[WIDTH-1];
      for (int unsigned k = 1; k < SH_W; k++) begin
        v_q[k]   <= v_q[k-1];
        d_q[k]   <= nxt[k];
        tag_q[k] <= tag_q[k-1];
      end
      for (int unsigned k = 1; k < SH_W - 1; k++) begin
        op_q[k]   <= op_q[k-1];
        sh_q[k]   <= sh_q[k-1];
        sign_q[k] <= sign_q[k-1];
      end
      zero_q <= (nxt[SH_W-1] == '0);
    end
  end

  assign out_valid = v_q[SH_W-1];
  assign out_data  = d_q[SH_W-1];
  assign out_tag   = tag_q[SH_W-1];
  assign out_zero  = zero_q;

`else

  logic [WIDTH-1:0] res;
  logic             v_q;
  logic [WIDTH-1:0] d_q;
  logic [TAG_W-1:0] tag_q;
  logic             zero_q;

  always_comb begin
    res = in_data;
    for (int unsigned k = 0; k < SH_W; k++) begin
      res = shift_stage(res, in_op, in_data[WIDTH-1], in_sh, k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      d_q    <= '0;
      tag_q  <= '0;
      zero_q <= 1'b0;
    end else if (advance) begin
      v_q    <= in_valid && in_ready;
      d_q    <= res;
      tag_q  <= in_tag;
      zero_q <= (res == '0);
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;
  assign out_tag   = tag_q;
  assign out_zero  = zero_q;

`endif

endmodule
